glip_channel_arbiter: RTL and testbench

GLIP_CHANNEL_ARBITER -- requirements
Module: glip_channel_arbiter

---
 rtl/glip_channel_arbiter_pkg.sv | 9 +
 rtl/glip_rr_select.sv | 32 +++
 rtl/glip_channel_arbiter.sv | 108 ++++++++++
 tb/tb_glip_channel_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/glip_channel_arbiter_pkg.sv
// Shared helpers for the glip channel arbiter slice.
package glip_channel_arbiter_pkg;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glip_rr_select.sv
// Rotating first-set selector: finds the first set req bit scanning ptr, ptr+1, ... modulo CHANNELS.
module glip_rr_select
    import glip_channel_arbiter_pkg::*;
#(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0]            req,
    input  logic [idx_width(CHANNELS)-1:0] ptr,
    output logic [idx_width(CHANNELS)-1:0] idx,
    output logic                           found
);

    localparam int IW = idx_width(CHANNELS);

    // Scan candidates in priority order; the first hit wins.
    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = (int'(ptr) + i) % CHANNELS;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IW'(cand);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/glip_channel_arbiter.sv
// Round-robin burst arbiter: grants one input channel at a time for up to BURST transfers,
// with a single IDLE cycle between grants.
module glip_channel_arbiter
    import glip_channel_arbiter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int BURST    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*WIDTH-1:0]      in_data,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [idx_width(CHANNELS)-1:0] out_channel
);

    localparam int IW = idx_width(CHANNELS);
    localparam int CW = idx_width(BURST);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
    localparam logic [IW-1:0] LAST_CH   = IW'(CHANNELS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [IW-1:0] grant_r, grant_s;
    logic [CW-1:0] count_r, count_s;
    logic [IW-1:0] sel_idx_s;
    logic          sel_found_s;
    logic          grant_valid_s;
    logic          xfer_s;

    glip_rr_select #(
        .CHANNELS(CHANNELS)
    ) u_rr_select (
        .req  (in_valid),
        .ptr  (ptr_r),
        .idx  (sel_idx_s),
        .found(sel_found_s)
    );

    // Arbitration state; reset returns to IDLE at once, which also silences all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
            count_r <= count_s;
        end
    end

    // Next-state and output decode; the granted channel is routed combinationally.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        grant_s       = grant_r;
        count_s       = count_r;
        out_valid     = 1'b0;
        out_data      = '0;
        out_channel   = '0;
        in_ready      = '0;
        grant_valid_s = in_valid[grant_r];
        xfer_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_found_s) begin
                    grant_s = sel_idx_s;
                    count_s = '0;
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                out_valid         = grant_valid_s;
                out_data          = in_data[grant_r*WIDTH +: WIDTH];
                out_channel       = grant_r;
                in_ready[grant_r] = out_ready;
                xfer_s            = grant_valid_s & out_ready;
                // A dropped request releases exactly like the final beat of a burst.
                if (!grant_valid_s || (xfer_s && (count_r == LAST_BEAT))) begin
                    state_s = IDLE;
                    ptr_s   = (grant_r == LAST_CH) ? '0 : grant_r + IW'(1);
                end else if (xfer_s) begin
                    count_s = count_r + CW'(1);
                end else begin
                    count_s = count_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_glip_channel_arbiter.sv
// Directed bench for glip_channel_arbiter (WIDTH=16, CHANNELS=4, BURST=4) with a per-channel scoreboard.
module tb_glip_channel_arbiter;

    logic        clk;
    logic        rst;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_channel;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic [15:0] src_q [4][$];
    logic [15:0] sb_q  [4][$];
    int          seq   [4];

    glip_channel_arbiter #(
        .WIDTH(16),
        .CHANNELS(4),
        .BURST(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_channel(out_channel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int ch, input int n);
        logic [15:0] w;
        for (int k = 0; k < n; k++) begin
            w = 16'(ch * 4096 + seq[ch]);
            seq[ch]++;
            src_q[ch].push_back(w);
            sb_q[ch].push_back(w);
        end
    endtask

    // One cycle starting at a negedge: drive sources, check outputs, retire transfers.
    task automatic step(input int exp_ch, input logic rdy);
        int ch;
        out_ready = rdy;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]         = (src_q[i].size() > 0);
            in_data[i*16 +: 16] = (src_q[i].size() > 0) ? src_q[i][0] : 16'h0000;
        end
        #1;
        if (exp_ch < 0) begin
            check_eq("out_valid_low", {31'b0, out_valid}, 32'd0);
        end else begin
            check_eq("out_valid_high", {31'b0, out_valid}, 32'd1);
            check_eq("out_channel", {30'b0, out_channel}, exp_ch);
        end
        if (out_valid) begin
            ch = int'(out_channel);
            check_eq("out_data", {16'b0, out_data}, (sb_q[ch].size() > 0) ? {16'b0, sb_q[ch][0]} : 32'hdead);
            check_eq("in_ready_grant", {28'b0, in_ready}, rdy ? (32'd1 << ch) : 32'd0);
            if (rdy && (sb_q[ch].size() > 0)) begin
                void'(sb_q[ch].pop_front());
            end
        end else begin
            check_eq("no_input_xfer", {28'b0, in_ready & in_valid}, 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                void'(src_q[i].pop_front());
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int exp_ch, input int n, input logic rdy);
        for (int k = 0; k < n; k++) begin
            step(exp_ch, rdy);
        end
    endtask

    // Assert reset at a negedge with current inputs still applied; outputs must drop at once.
    task automatic reset_dut(input string tag);
        rst = 1'b1;
        #1;
        check_eq({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check_eq({tag, "_in_ready"}, {28'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        @(negedge clk);
        in_valid = 4'b1111;
        reset_dut("por");
        in_valid = 4'b0000;

        // ch2 alone, 10 words: bursts 4,4,2 with one idle cycle between
        load(2, 10);
        run(-1, 1, 1'b1);
        run(2, 4, 1'b1);
        run(-1, 1, 1'b1);
        run(2, 4, 1'b1);
        run(-1, 1, 1'b1);
        run(2, 2, 1'b1);
        run(-1, 2, 1'b1);

        // all channels requesting: grants 0,1,2,3 then wrap to 0
        reset_dut("rst_b");
        load(0, 8);
        load(1, 4);
        load(2, 4);
        load(3, 4);
        run(-1, 1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            run(c, 4, 1'b1);
            run(-1, 1, 1'b1);
        end
        run(0, 4, 1'b1);
        run(-1, 2, 1'b1);

        // ch1 stalled by downstream after two beats, then finishes the burst
        reset_dut("rst_c");
        load(1, 4);
        run(-1, 1, 1'b1);
        run(1, 2, 1'b1);
        run(1, 5, 1'b0);
        run(1, 2, 1'b1);
        run(-1, 1, 1'b1);

        // ch3 drops valid mid-burst; ptr wraps so ch0 follows
        reset_dut("rst_d");
        load(2, 1);
        load(3, 2);
        run(-1, 1, 1'b1);
        run(2, 1, 1'b1);
        load(0, 3);
        run(-1, 2, 1'b1);
        run(3, 2, 1'b1);
        run(-1, 2, 1'b1);
        run(0, 3, 1'b1);
        run(-1, 2, 1'b1);

        // reset mid-burst on ch1; afterwards ch0 wins because scanning restarts at 0
        reset_dut("rst_e");
        load(1, 4);
        run(-1, 1, 1'b1);
        run(1, 2, 1'b1);
        reset_dut("mid_burst");
        load(0, 2);
        run(-1, 1, 1'b1);
        run(0, 2, 1'b1);
        run(-1, 2, 1'b1);
        run(1, 2, 1'b1);
        run(-1, 2, 1'b1);

        for (int i = 0; i < 4; i++) begin
            check_eq("sb_drained", sb_q[i].size(), 32'd0);
            check_eq("src_drained", src_q[i].size(), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
